vga_plot_arbiter: RTL and testbench

- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between several sprite drawers: character, obstacle, score.
- Uses round-robin grants with burst hold, so each drawer completes a sprite draw or erase pass without pixel interleaving.
- Sits between the sprite controller/datapath pairs and the VGA adapter. All pixel outputs are registered.

---
 rtl/vga_plot_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel-write port between sprite drawers.
// Define VGA_CLEAR_ON_RESET_EN to add a post-reset sweep that blanks the 160x120 screen.
module vga_plot_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 512
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   in_x,
    input  logic [7*NUM_REQ-1:0]   in_y,
    input  logic [3*NUM_REQ-1:0]   in_colour,
    input  logic [NUM_REQ-1:0]     in_plot,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_CLEAR
    } state_t;

`ifdef VGA_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           x_q, x_d;
    logic [6:0]           y_q, y_d;
    logic [2:0]           colour_q, colour_d;
    logic                 plot_q, plot_d;
    logic                 busy_q, busy_d;

    logic [IDX_W-1:0]     win;
    logic                 others_waiting;

`ifdef VGA_CLEAR_ON_RESET_EN
    logic [7:0]           cx_q, cx_d;
    logic [6:0]           cy_q, cy_d;
`endif

    // Rotating priority: the first request after the last winner takes the port.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        win   = last_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_q) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    assign others_waiting = |(req & ~grant_q);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
`ifdef VGA_CLEAR_ON_RESET_EN
        cx_d     = cx_q;
        cy_d     = cy_q;
`endif

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (|req) begin
                    state_d = S_GRANT;
                    grant_d = NUM_REQ'(1) << win;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end

            S_GRANT: begin
                x_d      = in_x[8*int'(last_q) +: 8];
                y_d      = in_y[7*int'(last_q) +: 7];
                colour_d = in_colour[3*int'(last_q) +: 3];
                plot_d   = in_plot[last_q];
                if (!req[last_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else if (cnt_q == CNT_TOP) begin
                    // A lone requester keeps the port; otherwise yield at the burst limit.
                    if (others_waiting) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef VGA_CLEAR_ON_RESET_EN
            S_CLEAR: begin
                grant_d  = '0;
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = 3'b000;
                plot_d   = 1'b1;
                if (cx_q == 8'd159) begin
                    cx_d = 8'd0;
                    if (cy_q == 7'd119) begin
                        cy_d    = 7'd0;
                        state_d = S_IDLE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RESET_STATE;
            grant_q  <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
        end
    end

`ifdef VGA_CLEAR_ON_RESET_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end
`endif

    assign grant      = grant_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: per-cycle vector table plus a pixel scoreboard.
// With VGA_CLEAR_ON_RESET_EN defined it checks the post-reset clear sweep instead.
module tb_vga_plot_arbiter;

    localparam int N  = 3;
    localparam int MB = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [8*N-1:0] in_x = '0;
    logic [7*N-1:0] in_y = '0;
    logic [3*N-1:0] in_colour = '0;
    logic [N-1:0]  in_plot = '0;
    logic [N-1:0]  grant;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic          busy;

    vga_plot_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_plot    (in_plot),
        .grant      (grant),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N-1:0]   plot;
        logic [8*N-1:0] x;
        logic [7*N-1:0] y;
        logic [3*N-1:0] c;
        logic [N-1:0]   g;
    } vec_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    vec_t tv[$];
    pix_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g == N'(1) << i) return i;
        return -1;
    endfunction

    // non99: every requester except the expected grantee presents x=99.
    task automatic add(input logic rst, input logic [N-1:0] r, input logic [N-1:0] p,
                       input logic [N-1:0] g, input logic non99);
        vec_t v;
        int   w;
        v.rst = rst; v.req = r; v.plot = p; v.g = g;
        v.x = N*8'($urandom); v.y = N*7'($urandom); v.c = N*3'($urandom);
        for (int i = 0; i < N; i++) begin
            v.x[8*i +: 8] = 8'($urandom);
            v.y[7*i +: 7] = 7'($urandom);
            v.c[3*i +: 3] = 3'($urandom);
        end
        if (non99) begin
            w = idx_of(g);
            for (int i = 0; i < N; i++)
                v.x[8*i +: 8] = (i == w) ? 8'($urandom_range(0, 98)) : 8'd99;
        end
        tv.push_back(v);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = '0;
        in_plot = '0;
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_pix", {vga_x, vga_y, vga_colour, vga_plot}, 0);
        check("rst_busy", 32'(busy), 0);
        hx = '0; hy = '0; hc = '0;
        reset_n = 1'b1;
    endtask

    task automatic pop_compare();
        pix_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("vga_x", 32'(vga_x), 32'(e.x));
            check("vga_y", 32'(vga_y), 32'(e.y));
            check("vga_colour", 32'(vga_colour), 32'(e.c));
            check("vga_plot", 32'(vga_plot), 32'(e.p));
        end
    endtask

`ifndef VGA_CLEAR_ON_RESET_EN
    initial begin
        vec_t v;
        pix_t e;
        int   w;
        // Single write then release.
        add(1, 3'b001, 3'b001, 3'b000, 0);
        add(0, 3'b001, 3'b001, 3'b001, 0);
        add(0, 3'b001, 3'b001, 3'b001, 0);
        add(0, 3'b000, 3'b000, 3'b001, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0);
        // Simultaneous requests, then drop with a bubble.
        add(1, 3'b011, 3'b011, 3'b000, 0);
        add(0, 3'b011, 3'b011, 3'b001, 0);
        add(0, 3'b011, 3'b011, 3'b001, 0);
        add(0, 3'b010, 3'b010, 3'b001, 0);
        add(0, 3'b010, 3'b010, 3'b000, 0);
        add(0, 3'b010, 3'b010, 3'b010, 0);
        add(0, 3'b000, 3'b000, 3'b010, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0);
        // Burst limit with two contenders.
        add(1, 3'b101, 3'b101, 3'b000, 0);
        for (int i = 0; i < MB; i++) add(0, 3'b101, 3'b101, 3'b001, 0);
        add(0, 3'b101, 3'b101, 3'b000, 0);
        for (int i = 0; i < MB; i++) add(0, 3'b101, 3'b101, 3'b100, 0);
        add(0, 3'b101, 3'b101, 3'b000, 0);
        add(0, 3'b101, 3'b101, 3'b001, 0);
        add(0, 3'b000, 3'b000, 3'b001, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0);
        // Lone requester keeps the port across counter wraps.
        add(1, 3'b010, 3'b010, 3'b000, 0);
        for (int i = 0; i < 20; i++) add(0, 3'b010, 3'b010, 3'b010, 0);
        add(0, 3'b000, 3'b000, 3'b010, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0);
        // Non-granted requesters toggle plot with x=99.
        add(1, 3'b001, 3'($urandom), 3'b000, 1);
        for (int i = 0; i < 6; i++) add(0, 3'b001, 3'($urandom), 3'b001, 1);
        add(0, 3'b000, 3'($urandom) & 3'b110, 3'b001, 1);
        add(0, 3'b000, 3'($urandom), 3'b000, 1);
        // Reset in the middle of a burst.
        add(1, 3'b001, 3'b001, 3'b000, 0);
        add(0, 3'b001, 3'b001, 3'b001, 0);
        add(0, 3'b001, 3'b001, 3'b001, 0);
        add(1, 3'b001, 3'b001, 3'b000, 0);
        add(0, 3'b001, 3'b001, 3'b001, 0);
        add(0, 3'b000, 3'b000, 3'b001, 0);
        add(0, 3'b000, 3'b000, 3'b000, 0);

        @(negedge clock);
        for (int k = 0; k < tv.size(); k++) begin
            v = tv[k];
            @(negedge clock);
            if (v.rst) begin
                apply_reset();
                sb.delete();
            end else begin
                pop_compare();
            end
            check("no_x99", 32'(vga_x == 8'd99), 0);
            req = v.req; in_plot = v.plot; in_x = v.x; in_y = v.y; in_colour = v.c;
            check("grant", 32'(grant), 32'(v.g));
            check("busy", 32'(busy), 32'(v.g != '0));
            w = idx_of(v.g);
            if (w >= 0) begin
                hx = v.x[8*w +: 8]; hy = v.y[7*w +: 7]; hc = v.c[3*w +: 3];
                e = '{x: hx, y: hy, c: hc, p: v.plot[w]};
            end else begin
                e = '{x: hx, y: hy, c: hc, p: 1'b0};
            end
            sb.push_back(e);
        end
        @(negedge clock);
        pop_compare();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`else
    initial begin
        int bad = 0;
        int plots = 0;
        req = '0;
        @(negedge clock);
        reset_n = 1'b1;
        // Partial sweep, then reset mid-way at cycle 5000.
        for (int n = 1; n <= 5000; n++) begin
            @(negedge clock);
            if (vga_plot !== 1'b1 || vga_x !== 8'((n-1) % 160) || vga_y !== 7'((n-1) / 160)
                || vga_colour !== 3'b000 || grant !== '0 || busy !== 1'b1) bad++;
        end
        check("sweep_partial", 32'(bad), 0);
        apply_reset();
        bad = 0;
        for (int n = 1; n <= 19201; n++) begin
            @(negedge clock);
            if (n == 1) check("restart_origin", {vga_x, vga_y, vga_plot}, {8'd0, 7'd0, 1'b1});
            if (vga_plot === 1'b1) plots++;
            if (n <= 19200) begin
                if (vga_plot !== 1'b1 || vga_x !== 8'((n-1) % 160) || vga_y !== 7'((n-1) / 160)
                    || vga_colour !== 3'b000 || grant !== '0 || busy !== (n < 19200)) bad++;
                if (n == 19200) check("last_pixel", {vga_x, vga_y}, {8'd159, 7'd119});
            end else begin
                check("post_plot", 32'(vga_plot), 0);
                check("post_grant", 32'(grant), 32'b001);
                check("post_busy", 32'(busy), 1);
            end
            if (n == 100) req = 3'b001;
        end
        check("sweep_full", 32'(bad), 0);
        check("plot_count", 32'(plots), 19200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`endif

endmodule
